// File: rtl/redun_to_bin_tx_pkg.sv
// Shared types, sizes and carry helpers for the redundant-to-binary streaming path.
package redun_to_bin_tx_pkg;

    localparam int unsigned WRD_BITS = 32;
    localparam int unsigned NUM_WRDS = 33;
    localparam int unsigned RWD_BITS = WRD_BITS + 1;
    localparam int unsigned SUM_BITS = WRD_BITS + 2;
    localparam int unsigned DAT_BITS = NUM_WRDS * WRD_BITS;
    localparam int unsigned DIN_BITS = NUM_WRDS * RWD_BITS;
    localparam int unsigned IDX_BITS = $clog2(NUM_WRDS);

    typedef logic [RWD_BITS-1:0] redun0_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // One serial normalization step: redundant word plus incoming 2-bit carry.
    function automatic logic [SUM_BITS-1:0] redun_carry_step(input redun0_t wrd,
                                                             input logic [1:0] carry);
        return SUM_BITS'(wrd) + SUM_BITS'(carry);
    endfunction

    // Full-width value of a redundant element, two guard bits above DAT_BITS.
    function automatic logic [DAT_BITS+1:0] redun_value(input logic [DIN_BITS-1:0] dat);
        logic [DAT_BITS+1:0] acc;
        acc = '0;
        for (int k = 0; k < int'(NUM_WRDS); k++) begin
            acc = acc + ((DAT_BITS+2)'(dat[k*RWD_BITS +: RWD_BITS]) << (k*WRD_BITS));
        end
        return acc;
    endfunction

    function automatic logic [DAT_BITS-1:0] from_redun(input logic [DIN_BITS-1:0] dat);
        logic [DAT_BITS+1:0] v;
        v = redun_value(dat);
        return v[DAT_BITS-1:0];
    endfunction

    function automatic logic check_overflow(input logic [DIN_BITS-1:0] dat);
        logic [DAT_BITS+1:0] v;
        v = redun_value(dat);
        return |v[DAT_BITS+1:DAT_BITS];
    endfunction

endpackage

// File: rtl/redun_to_bin_tx.sv
// Streams one redundant element out as normalized binary words, LSW first,
// resolving carries serially one word per accepted beat.
module redun_to_bin_tx
    import redun_to_bin_tx_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DIN_BITS-1:0] i_dat,
    input  logic                i_val,
    output logic                o_rdy,
    output logic [WRD_BITS-1:0] o_dat,
    output logic                o_val,
    input  logic                i_rdy,
    output logic                o_sop,
    output logic                o_eop,
    output logic                o_ovf
);

    tx_state_t           r_state;
    logic [IDX_BITS-1:0] r_idx;
    logic [1:0]          r_carry;
    redun0_t             r_wrd [NUM_WRDS];

    logic [SUM_BITS-1:0] w_sum;
    logic                w_send;
    logic                w_last;

    assign w_sum  = redun_carry_step(r_wrd[0], r_carry);
    assign w_last = (r_idx == IDX_BITS'(NUM_WRDS - 1));
    assign w_send = (r_state == ST_SEND) && !i_rst;

    // Control: state, beat index and running carry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_val) begin
                        r_state <= ST_SEND;
                        r_idx   <= '0;
                        r_carry <= '0;
                    end
                end
                ST_SEND: begin
                    if (i_rdy) begin
                        r_carry <= w_sum[WRD_BITS+1:WRD_BITS];
                        r_idx   <= r_idx + IDX_BITS'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Word store doubles as a right shifter so the current word is always slot 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (r_state == ST_IDLE) && i_val) begin
            for (int k = 0; k < int'(NUM_WRDS); k++) begin
                r_wrd[k] <= i_dat[k*RWD_BITS +: RWD_BITS];
            end
        end else if (!i_rst && (r_state == ST_SEND) && i_rdy) begin
            for (int k = 0; k < int'(NUM_WRDS) - 1; k++) begin
                r_wrd[k] <= r_wrd[k+1];
            end
            r_wrd[NUM_WRDS-1] <= '0;
        end
    end

    assign o_rdy = (r_state == ST_IDLE) && !i_rst;
    assign o_val = w_send;
    assign o_dat = w_send ? w_sum[WRD_BITS-1:0] : '0;
    assign o_sop = w_send && (r_idx == '0);
    assign o_eop = w_send && w_last;
    assign o_ovf = w_send && w_last && (w_sum[WRD_BITS+1:WRD_BITS] != 2'b00);

endmodule
